// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
// Provides the FSM state encoding and the default frame width and
// SCLK divider used by spi_master_ctrl and spi_bit_counter.
package spi_pkg;

    localparam int DEF_DATA_W  = 8;   // bits per frame
    localparam int DEF_CLK_DIV = 2;   // clk cycles per SCLK half-period

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for one SPI frame.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   clr       - synchronous clear (start of frame)
//   en        - count one transferred bit
//   count     - bits transferred so far
//   term_flag - high when count == DATA_W
// The counter saturates at DATA_W so it can never wrap inside a frame.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term_flag
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             term_flag_r;

    // Next count: clear has priority, increments stop at the terminal count
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (en && !term_flag_r) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with terminal flag registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {CNT_W{1'b0}};
            term_flag_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            term_flag_r <= (count_nxt_s == TERM_CNT);
        end
    end

    assign count     = count_r;
    assign term_flag = term_flag_r;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller, mode 0 (CPOL=0, CPHA=0).
// Accepts one frame over a valid/ready handshake, shifts it out MSB-first on
// mosi while capturing miso, and returns the received frame on rx_data.
// Ports:
//   clk, rst          - system clock and synchronous active-high reset
//   tx_valid/tx_ready - frame request handshake (ready only in IDLE)
//   tx_data           - frame to send, sampled on acceptance
//   rx_valid/rx_data  - one-cycle pulse with the received frame
//   busy              - high whenever the FSM is not IDLE
//   sclk, mosi, cs_n  - SPI outputs (all registered)
//   miso              - SPI input, already synchronised
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);

    spi_state_e        state_r;
    spi_state_e        state_nxt_s;
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  div_nxt_s;
    logic [DIV_W-1:0]  div_step_s;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_nxt_s;
    logic              sclk_r;
    logic              sclk_nxt_s;
    logic              mosi_r;
    logic              mosi_nxt_s;
    logic              cs_n_r;
    logic              cs_n_nxt_s;
    logic              rx_valid_r;
    logic              rx_valid_nxt_s;
    logic [DATA_W-1:0] rx_data_r;
    logic [DATA_W-1:0] rx_data_nxt_s;
    logic              tx_ready_r;
    logic              busy_r;

    logic              accept_s;
    logic              div_tc_s;
    logic              rise_s;
    logic              fall_s;
    logic              cnt_en_s;
    logic              cnt_clr_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              term_s;

    // Frame bit counter: cleared on accept, bumped on every SCLK rising edge
    spi_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr_s),
        .en        (cnt_en_s),
        .count     (cnt_s),
        .term_flag (term_s)
    );

    assign accept_s   = tx_valid && (state_r == IDLE);
    assign div_tc_s   = (div_r == DIV_TC);
    assign div_step_s = div_tc_s ? {DIV_W{1'b0}} : (div_r + DIV_ONE);
    // SCLK toggles only when the divider reaches terminal count in SHIFT
    assign rise_s     = (state_r == SHIFT) && div_tc_s && !sclk_r;
    assign fall_s     = (state_r == SHIFT) && div_tc_s &&  sclk_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SETUP;
                else          state_nxt_s = IDLE;
            end
            SETUP: begin
                if (div_tc_s) state_nxt_s = SHIFT;
                else          state_nxt_s = SETUP;
            end
            SHIFT: begin
                // The falling edge after the last capture ends the frame
                if (fall_s && term_s) state_nxt_s = HOLD;
                else                  state_nxt_s = SHIFT;
            end
            HOLD: begin
                if (div_tc_s) state_nxt_s = IDLE;
                else          state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and datapath
    always_comb begin
        div_nxt_s      = div_r;
        shreg_nxt_s    = shreg_r;
        sclk_nxt_s     = sclk_r;
        mosi_nxt_s     = mosi_r;
        cs_n_nxt_s     = cs_n_r;
        rx_valid_nxt_s = 1'b0;
        rx_data_nxt_s  = rx_data_r;
        cnt_en_s       = 1'b0;
        cnt_clr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                div_nxt_s  = {DIV_W{1'b0}};
                sclk_nxt_s = 1'b0;
                if (accept_s) begin
                    shreg_nxt_s = tx_data;
                    mosi_nxt_s  = tx_data[DATA_W-1];
                    cs_n_nxt_s  = 1'b0;
                    cnt_clr_s   = 1'b1;
                end else begin
                    cs_n_nxt_s  = 1'b1;
                end
            end
            SETUP: begin
                div_nxt_s  = div_step_s;
                sclk_nxt_s = 1'b0;
            end
            SHIFT: begin
                div_nxt_s = div_step_s;
                if (rise_s) begin
                    // Shift on capture: the MSB already sits on mosi, so the
                    // vacated LSB takes miso without losing untransmitted bits.
                    sclk_nxt_s  = 1'b1;
                    shreg_nxt_s = {shreg_r[DATA_W-2:0], miso};
                    cnt_en_s    = 1'b1;
                end else if (fall_s) begin
                    sclk_nxt_s = 1'b0;
                    // No new bit after the final capture
                    if (cnt_s < CNT_END) mosi_nxt_s = shreg_r[DATA_W-1];
                    else                 mosi_nxt_s = mosi_r;
                end else begin
                    sclk_nxt_s = sclk_r;
                end
            end
            HOLD: begin
                div_nxt_s  = div_step_s;
                sclk_nxt_s = 1'b0;
                if (div_tc_s) begin
                    cs_n_nxt_s     = 1'b1;
                    rx_data_nxt_s  = shreg_r;
                    rx_valid_nxt_s = 1'b1;
                    mosi_nxt_s     = 1'b0;
                end else begin
                    cs_n_nxt_s     = 1'b0;
                end
            end
            default: begin
                div_nxt_s  = {DIV_W{1'b0}};
                sclk_nxt_s = 1'b0;
                mosi_nxt_s = 1'b0;
                cs_n_nxt_s = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r      <= {DIV_W{1'b0}};
            shreg_r    <= {DATA_W{1'b0}};
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_data_r  <= {DATA_W{1'b0}};
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            div_r      <= div_nxt_s;
            shreg_r    <= shreg_nxt_s;
            sclk_r     <= sclk_nxt_s;
            mosi_r     <= mosi_nxt_s;
            cs_n_r     <= cs_n_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            tx_ready_r <= (state_nxt_s == IDLE);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign tx_ready = tx_ready_r;
    assign busy     = busy_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;
    assign cs_n     = cs_n_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: one instance with default
// parameters and one with CLK_DIV=1. A scoreboard entry is pushed on every
// accepted request and checked when the matching rx_valid pulse appears.
module tb_spi_master_ctrl;

    localparam int CD0  = 2;
    localparam int CD1  = 1;
    localparam int LAT0 = 1 + CD0 + 2 * 8 * CD0 + CD0;
    localparam int LAT1 = 1 + CD1 + 2 * 8 * CD1 + CD1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tv0, tv1;
    logic [7:0] tx_data;
    logic       miso_mode;   // 0: loopback, 1: miso held high
    logic       tr0, rv0, busy0, sclk0, mosi0, cs0, miso0;
    logic       tr1, rv1, busy1, sclk1, mosi1, cs1, miso1;
    logic [7:0] rxd0, rxd1;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso0 = miso_mode ? 1'b1 : mosi0;
    assign miso1 = miso_mode ? 1'b1 : mosi1;

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(CD0)) dut (
        .clk(clk), .rst(rst), .tx_valid(tv0), .tx_ready(tr0), .tx_data(tx_data),
        .rx_valid(rv0), .rx_data(rxd0), .busy(busy0), .sclk(sclk0),
        .mosi(mosi0), .miso(miso0), .cs_n(cs0)
    );

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(CD1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(tv1), .tx_ready(tr1), .tx_data(tx_data),
        .rx_valid(rv1), .rx_data(rxd1), .busy(busy1), .sclk(sclk1),
        .mosi(mosi1), .miso(miso1), .cs_n(cs1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Per-instance monitor state
    logic [1:0] tv_v, tr_v, rv_v, busy_v, sclk_v, mosi_v, cs_v;
    logic [7:0] rxd_v [2];
    int         rise_cnt [2];
    int         hi_run [2];
    logic [7:0] mosi_word [2];
    logic       prev_sclk [2];

    assign tv_v   = {tv1, tv0};
    assign tr_v   = {tr1, tr0};
    assign rv_v   = {rv1, rv0};
    assign busy_v = {busy1, busy0};
    assign sclk_v = {sclk1, sclk0};
    assign mosi_v = {mosi1, mosi0};
    assign cs_v   = {cs1, cs0};
    assign rxd_v[0] = rxd0;
    assign rxd_v[1] = rxd1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i] = 0; hi_run[i] = 0; mosi_word[i] = 8'h00; prev_sclk[i] = 1'b0;
        end
    end

    // Monitor: SCLK shape, mosi serialisation, scoreboard push and check
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (sclk_v[i] === 1'b1) begin
                if (prev_sclk[i] == 1'b0) begin
                    rise_cnt[i]++;
                    mosi_word[i] = {mosi_word[i][6:0], mosi_v[i]};
                    hi_run[i] = 1;
                end else begin
                    hi_run[i]++;
                end
            end else if (prev_sclk[i] == 1'b1 && busy_v[i] === 1'b1) begin
                check_val($sformatf("sclk_high_len%0d", i), hi_run[i], (i == 0) ? CD0 : CD1);
            end
            prev_sclk[i] = (sclk_v[i] === 1'b1);

            if (rv_v[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_val($sformatf("rx_spurious%0d", i), rv_v[i], 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check_val($sformatf("rx_data%0d", i), rxd_v[i], e.rx);
                    check_val($sformatf("latency%0d", i), cyc - e.acc, (i == 0) ? LAT0 : LAT1);
                    check_val($sformatf("sclk_rises%0d", i), rise_cnt[i], 8);
                    check_val($sformatf("mosi_bits%0d", i), mosi_word[i], e.tx);
                    check_val($sformatf("cs_n_at_rx%0d", i), cs_v[i], 1'b1);
                end
            end

            if (tv_v[i] === 1'b1 && tr_v[i] === 1'b1) begin
                e.tx  = tx_data;
                e.rx  = miso_mode ? 8'hFF : tx_data;
                e.acc = cyc;
                sb_q.push_back(e);
                rise_cnt[i]  = 0;
                mosi_word[i] = 8'h00;
            end
        end
    end

    task automatic send(input int inst, input logic [7:0] d);
        @(posedge clk); #1;
        tx_data = d;
        if (inst == 0) tv0 = 1'b1; else tv1 = 1'b1;
        @(posedge clk); #1;
        tv0 = 1'b0; tv1 = 1'b0;
        check_val("accepted", sb_q.size(), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && sb_q.size() != 0; k++) @(negedge clk);
        check_val("sb_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic mosi_seen;
        rst = 1'b1; tv0 = 1'b0; tv1 = 1'b0; tx_data = 8'h00; miso_mode = 1'b0;

        // Reset values
        @(posedge clk); @(negedge clk);
        check_val("rst_tx_ready", tr0, 1'b1);
        check_val("rst_rx_valid", rv0, 1'b0);
        check_val("rst_rx_data", rxd0, 8'h00);
        check_val("rst_busy", busy0, 1'b0);
        check_val("rst_sclk", sclk0, 1'b0);
        check_val("rst_mosi", mosi0, 1'b0);
        check_val("rst_cs_n", cs0, 1'b1);
        @(posedge clk); #1 rst = 1'b0;

        // Loopback 0xA5
        send(0, 8'hA5);
        wait_idle(60);
        @(negedge clk);
        check_val("idle_cs_n", cs0, 1'b1);
        check_val("idle_tx_ready", tr0, 1'b1);

        // miso high, tx 0x00: mosi must stay low for the whole frame
        miso_mode = 1'b1;
        send(0, 8'h00);
        mosi_seen = 1'b0;
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) begin
            @(negedge clk);
            mosi_seen = mosi_seen | mosi0;
        end
        check_val("mosi_low", mosi_seen, 1'b0);
        wait_idle(5);
        miso_mode = 1'b0;

        // Reset on the 15th cycle after accept
        send(0, 8'h5A);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("midrst_cs_n", cs0, 1'b1);
        check_val("midrst_sclk", sclk0, 1'b0);
        check_val("midrst_busy", busy0, 1'b0);
        check_val("midrst_tx_ready", tr0, 1'b1);
        check_val("midrst_rx_data", rxd0, 8'h00);
        repeat (45) @(negedge clk);
        send(0, 8'h3C);
        wait_idle(60);

        // Back-to-back: tx_valid held through two frames
        @(posedge clk); #1;
        tx_data = 8'h12; tv0 = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'h34;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rv0 === 1'b1) break;
        end
        check_val("b2b_rx_valid", rv0, 1'b1);
        @(posedge clk); #1 tv0 = 1'b0;
        @(negedge clk);
        check_val("b2b_cs_n_low", cs0, 1'b0);
        check_val("b2b_busy", busy0, 1'b1);
        wait_idle(60);

        // Request during SHIFT is ignored
        send(0, 8'h81);
        repeat (8) @(posedge clk);
        #1 tx_data = 8'hFF; tv0 = 1'b1;
        @(negedge clk);
        check_val("shift_tx_ready", tr0, 1'b0);
        check_val("shift_busy", busy0, 1'b1);
        @(posedge clk); #1 tv0 = 1'b0; tx_data = 8'h00;
        wait_idle(60);

        // CLK_DIV=1 instance, loopback 0xC3
        send(1, 8'hC3);
        wait_idle(40);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Sequencing controller for one SPI master transfer, mode 0 (CPOL=0, CPHA=0).
- Accepts a byte through a valid/ready handshake and generates SCLK from clk with a programmable divider.
- Shifts the byte out MSB-first on MOSI while capturing MISO, then returns the received byte.
- Tracks transferred bits with an internal bit counter that has a terminal-count flag, and drives that counter's enable and clear.

Parameters:
- DATA_W, 8, bits per frame; must be at least 2.
- CLK_DIV, 2, clk cycles per SCLK half-period; must be at least 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  request to start a frame with tx_data.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- tx_data  in  DATA_W  byte to send; sampled only on acceptance.
- rx_valid  out  1  one-cycle pulse when rx_data is valid.
- rx_data  out  DATA_W  received frame; holds its value until the next rx_valid.
- busy  out  1  high in every state except IDLE.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; already synchronised upstream.
- cs_n  out  1  active-low chip select.

Behaviour:
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, busy=0, sclk=0, mosi=0, cs_n=1, state=IDLE, shift register=0, divider=0, bit counter=0.
- Reset mid-frame: all outputs return to reset values on the next edge. No rx_valid is issued.

State machine: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - On accept, load the shift register with tx_data, drive cs_n=0 and mosi=tx_data[DATA_W-1] from the next cycle, and go to SETUP.
  - Clear the bit counter and the divider.
- SETUP:
  - Hold sclk=0 for CLK_DIV cycles (tCSS), then go to SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1. At terminal count, toggle sclk.
  - Rising SCLK edge: sample miso into the shift register LSB and pulse the bit counter enable.
  - Falling SCLK edge: shift left and present the next MSB on mosi.
  - When the counter's terminal flag is set (DATA_W rising edges done), the final falling edge returns sclk to 0 without a further shift, and the FSM goes to HOLD.
- HOLD:
  - Keep cs_n=0 and sclk=0 for CLK_DIV cycles (tCSH).
  - Then set cs_n=1, load rx_data from the shift register, pulse rx_valid for one cycle, and enter IDLE.
- Latency from the accept edge to the rx_valid cycle is 1 + CLK_DIV + 2·DATA_W·CLK_DIV + CLK_DIV cycles. With defaults this is 37 cycles.
- SCLK: exactly DATA_W rising edges per frame. High and low phases are each exactly CLK_DIV clk cycles.
- Request timing:
  - tx_valid while busy is ignored; there is no queueing.
  - tx_valid asserted in the same cycle rx_valid pulses is accepted, because the FSM is already in IDLE. This gives back-to-back frames with cs_n high for exactly 1 cycle.
- Changes on tx_data after acceptance have no effect on the frame in flight.
- Divider width is clog2(CLK_DIV), minimum 1. Bit counter width is clog2(DATA_W+1).
- The bit counter must not wrap within a frame. It is cleared only on accept or reset.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding constants: IDLE, SETUP, SHIFT, HOLD.
  - Defaults: DATA_W, CLK_DIV.
- One sub-module: spi_bit_counter.
  - Ports: clk, rst, clr, en, count, term_flag.
  - term_flag is high when count==DATA_W.
- The top level keeps the FSM, the clock divider and the shift register.

Test Plan:
- Loopback (miso tied to mosi), tx_data=0xA5 -> 8 sclk rising edges; mosi serialises 1,0,1,0,0,1,0,1; rx_valid at accept+37 cycles; rx_data=0xA5; cs_n high one cycle after rx_valid.
- miso held at 1, tx_data=0x00 -> rx_data=0xFF; mosi=0 throughout the frame.
- rst=1 on the 15th cycle after accept -> next edge: cs_n=1, sclk=0, busy=0, tx_ready=1; no rx_valid; the next frame with 0x3C completes correctly.
- tx_valid held high for two frames, 0x12 then 0x34 -> second frame accepted in the rx_valid cycle of the first; cs_n high for exactly 1 cycle; rx_data 0x12 then 0x34.
- CLK_DIV=1, DATA_W=8, loopback with 0xC3 -> sclk toggles every cycle; rx_valid at accept+19 cycles; rx_data=0xC3.
- tx_valid pulsed during SHIFT with tx_data=0xFF -> ignored; the current frame's mosi is unchanged; tx_ready stays 0 until IDLE.
